// File: rtl/pkt_pkg.sv
// Shared packet-parsing definitions: header offsets, parser states and the
// EtherType/version constants used by ipv4_dest_extractor and its neighbours.
package pkt_pkg;

    // Default Ethernet header length (untagged frame, no VLAN).
    localparam int unsigned ETH_HDR_LEN_DEF = 14;

    // Byte offsets from the start of the frame for the untagged layout.
    localparam int unsigned ETYPE_OFS  = 12;  // EtherType, MSB first
    localparam int unsigned IPVER_OFS  = 14;  // IPv4 version/IHL byte
    localparam int unsigned IPDST_OFS  = 30;  // first byte of destination IP
    localparam int unsigned IPDST_LAST = 33;  // last byte of destination IP

    // EtherType accepted as IPv4 and the version nibble expected in it.
    localparam logic [15:0] IPV4_ETHERTYPE_DEFAULT = 16'h0800;
    localparam logic [3:0]  IPV4_VERSION           = 4'd4;

    // PARSE: walking the headers of the current frame.
    // DRAIN: header emitted, passing the payload through until tlast.
    typedef enum logic {
        PARSE = 1'b0,
        DRAIN = 1'b1
    } parse_state_t;

    // True when a fully received header must be flagged as unusable.
    function automatic logic ipv4_hdr_bad(
        input logic [15:0] etype,
        input logic [15:0] want_etype,
        input logic [3:0]  version,
        input bit          check_version
    );
        return (etype != want_etype) ||
               (check_version && (version != IPV4_VERSION));
    endfunction

endpackage

// File: rtl/ipv4_dest_extractor_if.sv
// Bundle of the three buses around ipv4_dest_extractor: the ingress byte
// stream, the egress byte stream and the destination-IP header channel.
// slave is the extractor's view; master is the view of everything around it.
interface ipv4_dest_extractor_if;
    import pkt_pkg::*;

    // Ingress stream
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;

    // Egress stream towards the switch fabric
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;

    // Header channel towards the arbiter / ip_port_mapper
    logic [31:0] dest_ip;
    logic        hdr_err;
    logic        hdr_valid;
    logic        hdr_ready;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready, hdr_ready,
        output s_tready, m_tdata, m_tvalid, m_tlast,
               dest_ip, hdr_err, hdr_valid
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready, hdr_ready,
        input  s_tready, m_tdata, m_tvalid, m_tlast,
               dest_ip, hdr_err, hdr_valid
    );

endinterface

// File: rtl/ipv4_dest_extractor.sv
// Zero-latency tap on the ingress byte stream. Parses Ethernet + IPv4
// headers of each frame and offers the destination IP on a valid/ready
// header channel. Only one header can be pending; a new frame is held at
// its first byte until the pending header has been popped.
module ipv4_dest_extractor
    import pkt_pkg::*;
#(
    parameter int unsigned ETH_HDR_LEN    = ETH_HDR_LEN_DEF,
    parameter logic [15:0] IPV4_ETHERTYPE = IPV4_ETHERTYPE_DEFAULT,
    parameter bit          CHECK_VERSION  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    ipv4_dest_extractor_if.slave     bus
);

    // Offsets derived from the Ethernet header length so tagged layouts
    // only need a different ETH_HDR_LEN.
    localparam logic [5:0] OFS_ET_HI   = 6'(ETH_HDR_LEN - 2);
    localparam logic [5:0] OFS_ET_LO   = 6'(ETH_HDR_LEN - 1);
    localparam logic [5:0] OFS_VER     = 6'(ETH_HDR_LEN);
    localparam logic [5:0] OFS_DST     = 6'(ETH_HDR_LEN + 16);
    localparam logic [5:0] OFS_DST_END = 6'(ETH_HDR_LEN + 19);

    parse_state_t state;
    logic [5:0]   byte_cnt;
    logic [15:0]  et_reg;
    logic [3:0]   ver_reg;
    logic [23:0]  dst_sr;       // first three destination-IP bytes, MSB first

    logic [31:0]  dest_ip_r;
    logic         hdr_err_r;
    logic         hdr_valid_r;

    logic         gate;
    logic         accept;
    logic         pop;
    logic         in_dst;

    // Frame start is blocked while a header is still pending. The registered
    // hdr_valid is used, so a pop releases the stream one cycle later and the
    // first byte of the next frame never races an emission.
    assign gate   = !((state == PARSE) && (byte_cnt == 6'd0) && hdr_valid_r);
    assign accept = bus.s_tvalid && bus.s_tready;
    assign pop    = hdr_valid_r && bus.hdr_ready;
    assign in_dst = (byte_cnt >= OFS_DST) && (byte_cnt <= OFS_DST_END);

    assign bus.s_tready = bus.m_tready && gate;
    assign bus.m_tvalid = bus.s_tvalid && gate;
    assign bus.m_tdata  = bus.s_tdata;
    assign bus.m_tlast  = bus.s_tlast;

    assign bus.dest_ip   = dest_ip_r;
    assign bus.hdr_err   = hdr_err_r;
    assign bus.hdr_valid = hdr_valid_r;

    // Parser state, field capture and header emission.
    // NOTE: every register here, captured fields included, is reset because
    // a reset mid-frame must leave the next byte to be parsed as offset 0 with
    // no stale EtherType or version carried over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= PARSE;
            byte_cnt    <= '0;
            et_reg      <= '0;
            ver_reg     <= '0;
            dst_sr      <= '0;
            dest_ip_r   <= '0;
            hdr_err_r   <= 1'b0;
            hdr_valid_r <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the pop clear below be
            // overridden by an emission later in the same block, and keep
            // every read in this block looking at pre-edge values.
            if (pop) begin
                hdr_valid_r <= 1'b0;
            end

            if (accept) begin
                unique case (state)
                    PARSE: begin
                        if (byte_cnt == OFS_ET_HI) et_reg[15:8] <= bus.s_tdata;
                        if (byte_cnt == OFS_ET_LO) et_reg[7:0]  <= bus.s_tdata;
                        if (byte_cnt == OFS_VER)   ver_reg      <= bus.s_tdata[7:4];
                        if (in_dst)                dst_sr       <= {dst_sr[15:0], bus.s_tdata};

                        if (byte_cnt == OFS_DST_END) begin
                            // Full header seen: emit, then drain the payload.
                            dest_ip_r   <= {dst_sr, bus.s_tdata};
                            hdr_err_r   <= ipv4_hdr_bad(et_reg, IPV4_ETHERTYPE,
                                                        ver_reg, CHECK_VERSION);
                            hdr_valid_r <= 1'b1;
                            if (bus.s_tlast) begin
                                state    <= PARSE;
                                byte_cnt <= '0;
                            end else begin
                                state    <= DRAIN;
                            end
                        end else if (bus.s_tlast) begin
                            // Frame ended before the destination IP: flag it.
                            dest_ip_r   <= '0;
                            hdr_err_r   <= 1'b1;
                            hdr_valid_r <= 1'b1;
                            byte_cnt    <= '0;
                        end else begin
                            byte_cnt    <= byte_cnt + 6'd1;
                        end
                    end

                    DRAIN: begin
                        if (bus.s_tlast) begin
                            state    <= PARSE;
                            byte_cnt <= '0;
                        end
                    end

                    default: begin
                        state    <= PARSE;
                        byte_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ipv4_dest_extractor.sv
// Self-checking bench for ipv4_dest_extractor: directed scenarios plus
// randomized frames and stalls, checked against a frame-level model.
module tb_ipv4_dest_extractor;

    typedef logic [7:0] byte_t;
    typedef byte_t      frame_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ipv4_dest_extractor_if bus();

    ipv4_dest_extractor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    byte_t out_q[$];
    logic  out_last_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: what header a whole frame should produce.
    task automatic model(input frame_t f, output logic [31:0] ip, output logic err);
        if (f.size() < 34) begin
            ip  = 32'h0;
            err = 1'b1;
        end else begin
            ip  = {f[30], f[31], f[32], f[33]};
            err = ({f[12], f[13]} != 16'h0800) || (f[14][7:4] != 4'd4);
        end
    endtask

    task automatic build(input int len, input logic [15:0] et, input byte_t ver,
                         input logic [31:0] dst, output frame_t f);
        f = {};
        for (int k = 0; k < len; k++) f.push_back(byte_t'($urandom_range(255)));
        if (len > 12) f[12] = et[15:8];
        if (len > 13) f[13] = et[7:0];
        if (len > 14) f[14] = ver;
        for (int k = 0; k < 4; k++) if (len > 30 + k) f[30 + k] = dst[31 - 8*k -: 8];
    endtask

    // Present n bytes of frame f (tlast on its final byte), with random
    // s_tvalid/m_tready drops at stall_pct percent. Egress bytes are logged.
    task automatic send(input frame_t f, input int n, input int stall_pct, input bit chk_timing);
        int  i = 0;
        int  guard = 0;
        bit  after33 = 0;
        while (i < n) begin
            @(negedge clk);
            if (after33) begin
                check("hv_after_byte33", bus.hdr_valid, 1);
                after33 = 0;
            end
            bus.s_tvalid = ($urandom_range(99) >= stall_pct);
            bus.m_tready = ($urandom_range(99) >= stall_pct);
            bus.s_tdata  = f[i];
            bus.s_tlast  = (i == f.size() - 1);
            #1;
            if (bus.m_tvalid && bus.m_tready) begin
                if (chk_timing && i == 33) begin
                    check("hv_before_byte33", bus.hdr_valid, 0);
                    after33 = 1;
                end
                out_q.push_back(bus.m_tdata);
                out_last_q.push_back(bus.m_tlast);
                i++;
            end
            guard++;
            if (guard > 5000) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        @(negedge clk);
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.m_tready = 1'b1;
        if (after33) check("hv_after_byte33", bus.hdr_valid, 1);
    endtask

    // Compare the logged egress bytes with the frame, then clear the log.
    task automatic check_passthrough(input string tag, input frame_t f);
        int bad = 0;
        check({tag, "_len"}, out_q.size(), f.size());
        for (int k = 0; k < out_q.size() && k < f.size(); k++) begin
            if (out_q[k] !== f[k]) bad++;
            if (out_last_q[k] !== (k == f.size() - 1)) bad++;
        end
        check({tag, "_bytes"}, bad, 0);
        out_q      = {};
        out_last_q = {};
    endtask

    task automatic pop_hdr();
        @(negedge clk);
        bus.hdr_ready = 1'b1;
        @(negedge clk);
        bus.hdr_ready = 1'b0;
        #1;
        check("hv_cleared_by_pop", bus.hdr_valid, 0);
    endtask

    task automatic expect_hdr(input string tag, input logic [31:0] ip, input logic err, input bit do_pop);
        int waited = 0;
        while (bus.hdr_valid !== 1'b1 && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check({tag, "_valid"}, bus.hdr_valid, 1);
        check({tag, "_ip"}, bus.dest_ip, ip);
        check({tag, "_err"}, bus.hdr_err, err);
        if (do_pop) pop_hdr();
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.s_tvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_hdr_valid", bus.hdr_valid, 0);
        check("rst_dest_ip", bus.dest_ip, 0);
        check("rst_hdr_err", bus.hdr_err, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        frame_t      fa, fb, fr;
        logic [31:0] exp_ip;
        logic        exp_err;

        bus.s_tdata   = '0;
        bus.s_tvalid  = 1'b0;
        bus.s_tlast   = 1'b0;
        bus.m_tready  = 1'b1;
        bus.hdr_ready = 1'b0;

        // Power-on reset
        #1;
        check("por_hdr_valid", bus.hdr_valid, 0);
        check("por_dest_ip", bus.dest_ip, 0);
        check("por_hdr_err", bus.hdr_err, 0);
        check("por_s_tready", bus.s_tready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 60-byte IPv4 frame, no stalls, header left pending
        build(60, 16'h0800, 8'h45, 32'hC0A8010B, fa);
        send(fa, fa.size(), 0, 1);
        check_passthrough("ipv4_pt", fa);
        expect_hdr("ipv4", 32'hC0A8010B, 1'b0, 1'b0);

        // Next frame is held at byte 0 until the header is popped
        build(48, 16'h0800, 8'h45, 32'h0A000001, fb);
        repeat (3) begin
            @(negedge clk);
            bus.s_tvalid = 1'b1;
            bus.s_tdata  = fb[0];
            #1;
            check("b2b_held", bus.s_tready, 0);
        end
        @(negedge clk);
        bus.hdr_ready = 1'b1;
        #1;
        check("b2b_held_on_pop", bus.s_tready, 0);
        check("b2b_no_pass_on_pop", bus.m_tvalid, 0);
        @(negedge clk);
        bus.hdr_ready = 1'b0;
        bus.s_tvalid  = 1'b0;
        #1;
        check("b2b_released", bus.s_tready, 1);
        check("b2b_hv_cleared", bus.hdr_valid, 0);
        check("b2b_ip_held", bus.dest_ip, 32'hC0A8010B);
        send(fb, fb.size(), 0, 0);
        check_passthrough("b2b_pt", fb);
        expect_hdr("b2b", 32'h0A000001, 1'b0, 1'b1);

        // ARP frame: error flagged, IP bytes still reported as received
        build(42, 16'h0806, 8'h00, 32'h11223344, fr);
        send(fr, fr.size(), 0, 0);
        check_passthrough("arp_pt", fr);
        expect_hdr("arp", 32'h11223344, 1'b1, 1'b1);

        // Truncated 20-byte frame, then a normal one
        build(20, 16'h0800, 8'h45, 32'h0, fr);
        send(fr, fr.size(), 0, 0);
        check_passthrough("trunc_pt", fr);
        expect_hdr("trunc", 32'h0, 1'b1, 1'b1);
        build(34, 16'h0800, 8'h45, 32'hAC100005, fr);
        send(fr, fr.size(), 0, 0);
        check_passthrough("post_trunc_pt", fr);
        expect_hdr("post_trunc", 32'hAC100005, 1'b0, 1'b1);

        // Single-byte frame
        build(1, 16'h0, 8'h0, 32'h0, fr);
        send(fr, 1, 0, 0);
        check_passthrough("single_pt", fr);
        expect_hdr("single", 32'h0, 1'b1, 1'b1);

        // Bad version nibble
        build(40, 16'h0800, 8'h65, 32'h01020304, fr);
        send(fr, fr.size(), 0, 0);
        check_passthrough("badver_pt", fr);
        expect_hdr("badver", 32'h01020304, 1'b1, 1'b1);

        // Heavy random stalls on an IPv4 frame
        build(60, 16'h0800, 8'h45, 32'hC0A8010C, fr);
        send(fr, fr.size(), 40, 0);
        check_passthrough("stall_pt", fr);
        expect_hdr("stall", 32'hC0A8010C, 1'b0, 1'b1);

        // Reset at byte 25, with a previous non-zero dest_ip still held
        build(60, 16'h0800, 8'h45, 32'hDEADBEEF, fr);
        send(fr, 25, 0, 0);
        do_reset();
        out_q      = {};
        out_last_q = {};
        build(50, 16'h0800, 8'h45, 32'h0B0C0D0E, fr);
        send(fr, fr.size(), 0, 0);
        check_passthrough("post_rst_pt", fr);
        expect_hdr("post_rst", 32'h0B0C0D0E, 1'b0, 1'b1);

        // Random frames against the model
        for (int t = 0; t < 10; t++) begin
            int          len;
            logic [15:0] et;
            byte_t       ver;
            len = $urandom_range(70, 1);
            et  = ($urandom_range(99) < 70) ? 16'h0800 : 16'($urandom_range(16'hFFFF));
            ver = ($urandom_range(99) < 80) ? 8'h45 : byte_t'($urandom_range(255));
            build(len, et, ver, $urandom, fr);
            model(fr, exp_ip, exp_err);
            send(fr, fr.size(), 30, 0);
            check_passthrough("rand_pt", fr);
            expect_hdr("rand", exp_ip, exp_err, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
